cache_refill_collector: RTL and testbench

Write-side companion to the cache data-array registers. Accepts a refill request for one line index, collects BEATS memory-bus data beats over a valid/ready channel, and assembles them into one full-line write. It then presents the line to the data array as a single enable-qualified write, held until the array accepts it. It sits between the refill bus interface and the cache data-array write port.

---
 rtl/cache_refill_collector.sv | 118 +++++++++++
 tb/tb_cache_refill_collector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_collector.sv
// Collects BEATS bus beats for one refill request and issues them as a single full-line write.
// Optional beat_last_i checking is enabled by defining REFILL_LAST_CHECK_EN.
module cache_refill_collector #(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned IDX_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid_i,
  input  logic [IDX_WIDTH-1:0]        req_idx_i,
  output logic                        req_ready_o,
  input  logic                        beat_valid_i,
  input  logic [BEAT_WIDTH-1:0]       beat_data_i,
  input  logic                        beat_last_i,
  output logic                        beat_ready_o,
  output logic                        wr_en_o,
  output logic [IDX_WIDTH-1:0]        wr_idx_o,
  output logic [BEAT_WIDTH*BEATS-1:0] wr_data_o,
  input  logic                        wr_ready_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned CntWidth = $clog2(BEATS);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e                               state_q, state_d;
  logic [CntWidth-1:0]                  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]                 idx_q, idx_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]     line_q, line_d;
  logic                                 err_q, err_d;

`ifndef REFILL_LAST_CHECK_EN
  logic unused_beat_last;
  assign unused_beat_last = beat_last_i;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    line_d       = line_q;
    err_d        = 1'b0;
    req_ready_o  = 1'b0;
    beat_ready_o = 1'b0;
    wr_en_o      = 1'b0;
    wr_idx_o     = '0;
    wr_data_o    = '0;

    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          idx_d   = req_idx_i;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        beat_ready_o = 1'b1;
        if (beat_valid_i) begin
          line_d[cnt_q] = beat_data_i;
          cnt_d         = cnt_q + CntWidth'(1);
`ifdef REFILL_LAST_CHECK_EN
          // A misplaced or missing last marker drops the whole line.
          if (beat_last_i != (cnt_q == LastCnt)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (cnt_q == LastCnt) begin
            state_d = StWrite;
          end
`else
          if (cnt_q == LastCnt) begin
            state_d = StWrite;
          end
`endif
        end
      end
      StWrite: begin
        wr_en_o   = 1'b1;
        wr_idx_o  = idx_q;
        wr_data_o = line_q;
        if (wr_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

`ifdef REFILL_LAST_CHECK_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cache_refill_collector.sv
// Self-checking bench for cache_refill_collector: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_cache_refill_collector;

  localparam int BW = 64;
  localparam int NB = 4;
  localparam int IW = 6;
  localparam int LW = BW * NB;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic [IW-1:0] req_idx;
  logic          req_ready;
  logic          beat_valid;
  logic [BW-1:0] beat_data;
  logic          beat_last;
  logic          beat_ready;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [LW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic          err;

  int n_chk = 0;
  int n_err = 0;

  cache_refill_collector #(
    .BEAT_WIDTH(BW),
    .BEATS     (NB),
    .IDX_WIDTH (IW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_idx_i   (req_idx),
    .req_ready_o (req_ready),
    .beat_valid_i(beat_valid),
    .beat_data_i (beat_data),
    .beat_last_i (beat_last),
    .beat_ready_o(beat_ready),
    .wr_en_o     (wr_en),
    .wr_idx_o    (wr_idx),
    .wr_data_o   (wr_data),
    .wr_ready_i  (wr_ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [IW-1:0] ri;
    logic          bv;
    logic [BW-1:0] bd;
    logic          bl;
    logic          wrdy;
    logic          e_rr;
    logic          e_br;
    logic          e_we;
    logic [IW-1:0] e_idx;
    logic [LW-1:0] e_data;
    logic          e_busy;
  } vec_t;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rr, input logic br, input logic we,
                         input logic [IW-1:0] wi, input logic [LW-1:0] wd, input logic bz,
                         input logic er);
    check({tag, ".req_ready"}, LW'(req_ready), LW'(rr));
    check({tag, ".beat_ready"}, LW'(beat_ready), LW'(br));
    check({tag, ".wr_en"}, LW'(wr_en), LW'(we));
    check({tag, ".wr_idx"}, LW'(wr_idx), LW'(wi));
    check({tag, ".wr_data"}, wr_data, wd);
    check({tag, ".busy"}, LW'(busy), LW'(bz));
    check({tag, ".err"}, LW'(err), LW'(er));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_idx    = '0;
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_last  = 1'b0;
    wr_ready   = 1'b0;
  endtask

  // Request idx, then push NB back-to-back beats base+k with last on the final one.
  task automatic send_line(input string tag, input logic [IW-1:0] idx, input logic [BW-1:0] base,
                           output logic [LW-1:0] line);
    line      = '0;
    req_valid = 1'b1;
    req_idx   = idx;
    chk_all({tag, ".req"}, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      beat_valid = 1'b1;
      beat_data  = base + BW'(k);
      beat_last  = (k == NB - 1);
      line[k*BW +: BW] = beat_data;
      check({tag, ".collect_br"}, LW'(beat_ready), LW'(1'b1));
      cyc();
    end
    beat_valid = 1'b0;
    beat_last  = 1'b0;
  endtask

  vec_t          vecs[7];
  logic [LW-1:0] line_exp;
  logic [LW-1:0] tmp_line;

  // Reference model state
  int            m_phase;
  logic [IW-1:0] m_idx;
  logic [BW-1:0] m_q[$];
  logic          m_err;

  initial begin
    line_exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    vecs[0] = '{1'b1, 6'h15, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0};
    vecs[1] = '{1'b0, 6'h00, 1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 6'h0, '0, 1'b1};
    vecs[2] = '{1'b0, 6'h00, 1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 6'h0, '0, 1'b1};
    vecs[3] = '{1'b0, 6'h00, 1'b1, 64'h3333_3333_3333_3333, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 6'h0, '0, 1'b1};
    vecs[4] = '{1'b0, 6'h00, 1'b1, 64'h4444_4444_4444_4444, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0, 6'h0, '0, 1'b1};
    vecs[5] = '{1'b0, 6'h00, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h15, line_exp, 1'b1};
    vecs[6] = '{1'b0, 6'h00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0};

    rstn = 1'b0;
    idle_inputs();
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    cyc();

    // Basic refill from the vector table
    for (int i = 0; i < 7; i++) begin
      req_valid  = vecs[i].rv;
      req_idx    = vecs[i].ri;
      beat_valid = vecs[i].bv;
      beat_data  = vecs[i].bd;
      beat_last  = vecs[i].bl;
      wr_ready   = vecs[i].wrdy;
      chk_all($sformatf("basic[%0d]", i), vecs[i].e_rr, vecs[i].e_br, vecs[i].e_we,
              vecs[i].e_idx, vecs[i].e_data, vecs[i].e_busy, 1'b0);
      cyc();
    end
    idle_inputs();

    // Bubbles: valid on every other cycle
    req_valid = 1'b1;
    req_idx   = 6'h2A;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 2 * NB - 1; i++) begin
      beat_valid = (i % 2 == 0);
      beat_data  = (i % 2 == 0) ? line_exp[(i/2)*BW +: BW] : 64'hDEAD_BEEF_DEAD_BEEF;
      beat_last  = (i == 2 * NB - 2);
      check("bubble.br", LW'(beat_ready), LW'(1'b1));
      check("bubble.we", LW'(wr_en), LW'(1'b0));
      cyc();
    end
    idle_inputs();
    wr_ready = 1'b1;
    chk_all("bubble.wr", 1'b0, 1'b0, 1'b1, 6'h2A, line_exp, 1'b1, 1'b0);
    cyc();
    wr_ready = 1'b0;
    chk_all("bubble.idle", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Write backpressure with a competing request offered throughout
    send_line("bp", 6'h07, 64'hA5A5_0000_0000_0100, tmp_line);
    req_valid = 1'b1;
    req_idx   = 6'h09;
    for (int i = 0; i < 6; i++) begin
      wr_ready = (i == 5);
      chk_all($sformatf("bp.hold[%0d]", i), 1'b0, 1'b0, 1'b1, 6'h07, tmp_line, 1'b1, 1'b0);
      cyc();
    end
    wr_ready = 1'b0;
    chk_all("bp.newreq", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    req_valid = 1'b0;
    check("bp.collect", LW'(beat_ready), LW'(1'b1));
    for (int k = 0; k < NB; k++) begin
      beat_valid = 1'b1;
      beat_data  = 64'h0909_0000_0000_0000 + BW'(k);
      beat_last  = (k == NB - 1);
      tmp_line[k*BW +: BW] = beat_data;
      cyc();
    end
    idle_inputs();
    wr_ready = 1'b1;
    chk_all("bp.wr2", 1'b0, 1'b0, 1'b1, 6'h09, tmp_line, 1'b1, 1'b0);
    cyc();
    wr_ready = 1'b0;

    // Reset mid-collect
    req_valid = 1'b1;
    req_idx   = 6'h3F;
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat_valid = 1'b1;
      beat_data  = 64'hAAAA_AAAA_AAAA_AAAA;
      cyc();
    end
    idle_inputs();
    rstn = 1'b0;
    #1;
    chk_all("rst_mid", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk) rstn = 1'b1;
    cyc();
    send_line("rst_after", 6'h03, 64'h5555_0000_0000_0000, tmp_line);
    wr_ready = 1'b1;
    chk_all("rst_after.wr", 1'b0, 1'b0, 1'b1, 6'h03, tmp_line, 1'b1, 1'b0);
    cyc();
    wr_ready = 1'b0;

    // Early last on beat 1
    req_valid = 1'b1;
    req_idx   = 6'h10;
    cyc();
    req_valid = 1'b0;
    tmp_line  = '0;
    for (int k = 0; k < 2; k++) begin
      beat_valid = 1'b1;
      beat_data  = 64'hE0 + BW'(k);
      beat_last  = (k == 1);
      tmp_line[k*BW +: BW] = beat_data;
      cyc();
    end
    idle_inputs();
`ifdef REFILL_LAST_CHECK_EN
    chk_all("early.err", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    chk_all("early.after", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
`else
    chk_all("early.noerr", 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 2; k < NB; k++) begin
      beat_valid = 1'b1;
      beat_data  = 64'hE0 + BW'(k);
      beat_last  = (k == NB - 1);
      tmp_line[k*BW +: BW] = beat_data;
      check("early.err0", LW'(err), LW'(1'b0));
      cyc();
    end
    idle_inputs();
    wr_ready = 1'b1;
    chk_all("early.wr", 1'b0, 1'b0, 1'b1, 6'h10, tmp_line, 1'b1, 1'b0);
    cyc();
    idle_inputs();
`endif

    // Randomized run against the reference model
    m_phase = 0;
    m_idx   = '0;
    m_q.delete();
    m_err   = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [LW-1:0] e_data;
      logic          correct_last;
      logic          n_err_flag;
      req_valid    = ($urandom_range(0, 3) == 0);
      req_idx      = IW'($urandom);
      beat_valid   = ($urandom_range(0, 2) != 0);
      beat_data    = {$urandom, $urandom};
      correct_last = (m_q.size() == NB - 1);
`ifdef REFILL_LAST_CHECK_EN
      beat_last    = ($urandom_range(0, 9) == 0) ? ~correct_last : correct_last;
`else
      beat_last    = 1'($urandom);
`endif
      wr_ready     = ($urandom_range(0, 2) == 0);

      e_data = '0;
      if (m_phase == 2) begin
        for (int k = 0; k < NB; k++) e_data[k*BW +: BW] = m_q[k];
      end
      chk_all("rand", m_phase == 0, m_phase == 1, m_phase == 2,
              (m_phase == 2) ? m_idx : '0, e_data, m_phase != 0, m_err);

      n_err_flag = 1'b0;
      case (m_phase)
        0: if (req_valid) begin
          m_idx = req_idx;
          m_q.delete();
          m_phase = 1;
        end
        1: if (beat_valid) begin
          m_q.push_back(beat_data);
`ifdef REFILL_LAST_CHECK_EN
          if (beat_last != (m_q.size() == NB)) begin
            n_err_flag = 1'b1;
            m_phase = 0;
          end else if (m_q.size() == NB) begin
            m_phase = 2;
          end
`else
          if (m_q.size() == NB) m_phase = 2;
`endif
        end
        default: if (wr_ready) m_phase = 0;
      endcase
      m_err = n_err_flag;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
